// File: rtl/video_fb_input_pkg.sv
// Shared types and helpers for the framebuffer video capture path.
package video_fb_input_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } fb_state_t;

    typedef logic [23:0] pixel_t;

    // Counters must hold n+1 so that overlong lines/frames stay distinguishable from exact ones.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/video_geom_check.sv
// Line/frame geometry measurement on a registered sync/den stream.
// Produces the per-frame verdict at each vsync start.
module video_geom_check
    import video_fb_input_pkg::*;
#(
    parameter int h_visible = 1920,
    parameter int v_visible = 1080
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               vs_act,
    input  logic                               den,
    output logic                               vs_start,
    output logic                               den_fall,
    output logic                               good,
    output logic [cnt_width(h_visible)-1:0]    x_cnt,
    output logic [cnt_width(v_visible)-1:0]    y_cnt
);

    localparam int XW = cnt_width(h_visible);
    localparam int YW = cnt_width(v_visible);
    localparam logic [XW-1:0] X_FULL = XW'(h_visible);
    localparam logic [XW-1:0] X_SAT  = XW'(h_visible + 1);
    localparam logic [YW-1:0] Y_FULL = YW'(v_visible);
    localparam logic [YW-1:0] Y_SAT  = YW'(v_visible + 1);

    logic          vs_act_d_reg;
    logic          den_d_reg;
    logic          line_err_reg, line_err_next;
    logic [XW-1:0] x_cnt_reg, x_cnt_next;
    logic [YW-1:0] y_cnt_reg, y_cnt_next;

    assign vs_start = vs_act & ~vs_act_d_reg;
    assign den_fall = ~den & den_d_reg;
    assign x_cnt    = x_cnt_reg;
    assign y_cnt    = y_cnt_reg;

    always_comb begin
        x_cnt_next    = x_cnt_reg;
        y_cnt_next    = y_cnt_reg;
        line_err_next = line_err_reg;
        if (den && x_cnt_reg != X_SAT) begin
            x_cnt_next = x_cnt_reg + XW'(1);
        end
        if (den_fall) begin
            x_cnt_next = '0;
            if (y_cnt_reg != Y_SAT) begin
                y_cnt_next = y_cnt_reg + YW'(1);
            end
            if (x_cnt_reg != X_FULL) begin
                line_err_next = 1'b1;
            end
        end
        // Verdict includes a line ending in the same cycle as vsync start.
        good = (y_cnt_next == Y_FULL) && !line_err_next;
        if (vs_start) begin
            x_cnt_next    = '0;
            y_cnt_next    = '0;
            line_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_d_reg <= 1'b0;
            den_d_reg    <= 1'b0;
            line_err_reg <= 1'b0;
            x_cnt_reg    <= '0;
            y_cnt_reg    <= '0;
        end else begin
            vs_act_d_reg <= vs_act;
            den_d_reg    <= den;
            line_err_reg <= line_err_next;
            x_cnt_reg    <= x_cnt_next;
            y_cnt_reg    <= y_cnt_next;
        end
    end

endmodule

// File: rtl/video_fb_input.sv
// Framebuffer capture front end: qualifies incoming frame geometry and
// forwards pixels to the framebuffer write port only while locked.
module video_fb_input
    import video_fb_input_pkg::*;
#(
    parameter int   video_h_visible = 1920,
    parameter int   video_v_visible = 1080,
    parameter logic video_hsync_pol = 1'b1,
    parameter logic video_vsync_pol = 1'b1
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    input  logic        video_vsync,
    input  logic        video_hsync,
    input  logic        video_den,
    input  logic [23:0] video_data,
    output logic        fbc_vsync,
    output logic        fbc_we,
    output logic [23:0] fbc_data,
    output logic        frame_locked,
    output logic        frame_error
);

    localparam int XW = cnt_width(video_h_visible);
    localparam int YW = cnt_width(video_v_visible);
    localparam logic [XW-1:0] H_LIM = XW'(video_h_visible);
    localparam logic [YW-1:0] V_LIM = YW'(video_v_visible);

    logic      vs_act_reg;
    logic      unused_hs_act_reg;
    logic      den_reg;
    pixel_t    data_reg;

    logic          vs_start;
    logic          den_fall;
    logic          good;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    fb_state_t state_reg, state_next;
    logic      frame_error_next;
    logic      lock_ok;
    logic      we_next;

    logic      fbc_vsync_reg;
    logic      fbc_we_reg;
    pixel_t    fbc_data_reg;
    logic      frame_locked_reg;
    logic      frame_error_reg;

    // Polarity is normalised before registering so the sync flops reset to "inactive".
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_act_reg        <= 1'b0;
            unused_hs_act_reg <= 1'b0;
            den_reg           <= 1'b0;
            data_reg          <= '0;
        end else begin
            vs_act_reg        <= video_vsync ~^ video_vsync_pol;
            unused_hs_act_reg <= video_hsync ~^ video_hsync_pol;
            den_reg           <= video_den;
            data_reg          <= video_data;
        end
    end

    video_geom_check #(
        .h_visible (video_h_visible),
        .v_visible (video_v_visible)
    ) u_geom (
        .clk      (pixel_clock),
        .rst_n    (reset_n),
        .vs_act   (vs_act_reg),
        .den      (den_reg),
        .vs_start (vs_start),
        .den_fall (den_fall),
        .good     (good),
        .x_cnt    (x_cnt),
        .y_cnt    (y_cnt)
    );

    always_comb begin
        state_next       = state_reg;
        frame_error_next = 1'b0;
        if (vs_start) begin
            case (state_reg)
                SEARCH:  state_next = MEASURE;
                MEASURE: if (good) state_next = LOCKED;
                LOCKED: begin
                    if (!good) begin
                        state_next       = MEASURE;
                        frame_error_next = 1'b1;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Entering LOCKED on this vsync start opens the gate for the new frame immediately.
    assign lock_ok = (state_reg == LOCKED) || (state_next == LOCKED);
    assign we_next = den_reg && lock_ok && (y_cnt < V_LIM) && (x_cnt < H_LIM);

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            fbc_vsync_reg    <= 1'b0;
            fbc_we_reg       <= 1'b0;
            fbc_data_reg     <= '0;
            frame_locked_reg <= 1'b0;
            frame_error_reg  <= 1'b0;
        end else begin
            fbc_vsync_reg    <= vs_act_reg && lock_ok;
            fbc_we_reg       <= we_next;
            fbc_data_reg     <= we_next ? data_reg : '0;
            frame_locked_reg <= (state_next == LOCKED);
            frame_error_reg  <= frame_error_next;
        end
    end

    assign fbc_vsync    = fbc_vsync_reg;
    assign fbc_we       = fbc_we_reg;
    assign fbc_data     = fbc_data_reg;
    assign frame_locked = frame_locked_reg;
    assign frame_error  = frame_error_reg;

endmodule

// File: tb/tb_video_fb_input.sv
// Drives one pixel stream into a positive- and a negative-vsync-polarity instance
// and checks both against a frame-level reference model.
module tb_video_fb_input;
    import video_fb_input_pkg::*;

    localparam int H = 8;
    localparam int V = 4;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    logic   vsync_i = 1'b0;
    logic   hsync_i = 1'b0;
    logic   den_i = 1'b0;
    pixel_t data_i = '0;
    logic   vsync_neg;
    logic   hsync_neg;

    logic [1:0] fbc_vsync_v, fbc_we_v, locked_v, error_v;
    pixel_t     data_v0, data_v1;

    assign vsync_neg = ~vsync_i;
    assign hsync_neg = ~hsync_i;

    video_fb_input #(
        .video_h_visible (H), .video_v_visible (V),
        .video_hsync_pol (1'b1), .video_vsync_pol (1'b1)
    ) dut_pos (
        .pixel_clock (clk), .reset_n (reset_n),
        .video_vsync (vsync_i), .video_hsync (hsync_i),
        .video_den (den_i), .video_data (data_i),
        .fbc_vsync (fbc_vsync_v[0]), .fbc_we (fbc_we_v[0]), .fbc_data (data_v0),
        .frame_locked (locked_v[0]), .frame_error (error_v[0])
    );

    video_fb_input #(
        .video_h_visible (H), .video_v_visible (V),
        .video_hsync_pol (1'b0), .video_vsync_pol (1'b0)
    ) dut_neg (
        .pixel_clock (clk), .reset_n (reset_n),
        .video_vsync (vsync_neg), .video_hsync (hsync_neg),
        .video_den (den_i), .video_data (data_i),
        .fbc_vsync (fbc_vsync_v[1]), .fbc_we (fbc_we_v[1]), .fbc_data (data_v1),
        .frame_locked (locked_v[1]), .frame_error (error_v[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        pixel_t d;
        int     c;
    } wr_t;

    wr_t exp_q0[$];
    wr_t exp_q1[$];
    wr_t e0, e1;
    int  wr_total[2];
    int  wr_snap[2];
    int  exp_writes = 0;
    int  total_checks = 0;
    int  pass_checks = 0;
    int  fail_checks = 0;
    int  vs_count = 0;

    // Frame-level model state: a frame is written iff the previous frame began
    // with a vsync since reset and had exactly V lines of exactly H pixels.
    bit prev_valid = 0;
    bit prev_good = 0;
    bit prev_written = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_checks++;
        assert (obs === expv) pass_checks++;
        else begin
            fail_checks++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (fbc_we_v[0]) begin
            wr_total[0]++;
            if (exp_q0.size() == 0) chk("we_extra_pos", 32'(fbc_we_v[0]), 0);
            else begin
                e0 = exp_q0.pop_front();
                chk("data_pos", 32'(data_v0), 32'(e0.d));
                chk("latency_pos", cyc, e0.c);
            end
        end else begin
            chk("idle_data_pos", 32'(data_v0), 0);
        end
        if (fbc_we_v[1]) begin
            wr_total[1]++;
            if (exp_q1.size() == 0) chk("we_extra_neg", 32'(fbc_we_v[1]), 0);
            else begin
                e1 = exp_q1.pop_front();
                chk("data_neg", 32'(data_v1), 32'(e1.d));
                chk("latency_neg", cyc, e1.c);
            end
        end else begin
            chk("idle_data_neg", 32'(data_v1), 0);
        end
    end

    // Drive one input cycle (called at a negedge) and return at the next negedge.
    task automatic cycle(input logic vs, input logic hs, input logic de, input pixel_t d, input bit wr);
        wr_t w;
        vsync_i = vs;
        hsync_i = hs;
        den_i   = de;
        data_i  = d;
        if (wr) begin
            w.d = d;
            w.c = cyc + 2;
            exp_q0.push_back(w);
            exp_q1.push_back(w);
            exp_writes++;
        end
        @(negedge clk);
    endtask

    task automatic reset_midline();
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_async_we", 32'(fbc_we_v[i]), 0);
            chk("rst_async_data", (i == 0) ? 32'(data_v0) : 32'(data_v1), 0);
            chk("rst_async_vsync", 32'(fbc_vsync_v[i]), 0);
            chk("rst_async_locked", 32'(locked_v[i]), 0);
            chk("rst_async_error", 32'(error_v[i]), 0);
        end
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) wr_snap[i] = wr_total[i];
        exp_writes = 0;
        reset_n = 1'b1;
        $display("reset pulse applied mid-line at cycle %0d", cyc);
    endtask

    task automatic send_frame(input bit has_vs, input int nlines, input int bad_line,
                              input int bad_len, input bit coinc, input int rst_line);
        bit     written, exp_err, good, rst_hit;
        int     len;
        pixel_t d;
        written = has_vs && prev_valid && prev_good;
        exp_err = has_vs && prev_written && !prev_good;
        rst_hit = 0;
        if (has_vs) begin
            vs_count++;
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                chk("locked_before", 32'(locked_v[i]), 32'(prev_written));
                chk("error_before", 32'(error_v[i]), 0);
            end
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                chk("locked_after", 32'(locked_v[i]), 32'(written));
                chk("error_pulse", 32'(error_v[i]), 32'(exp_err));
                chk("fbc_vsync_start", 32'(fbc_vsync_v[i]), 32'(prev_written || written));
                chk("frame_writes", wr_total[i] - wr_snap[i], exp_writes);
            end
            $display("vsync %0d: prev frame writes=%0d good=%0b, now locked=%0b error=%0b",
                     vs_count, wr_total[0] - wr_snap[0], prev_good, locked_v[0], error_v[0]);
            for (int i = 0; i < 2; i++) wr_snap[i] = wr_total[i];
            exp_writes = 0;
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
            for (int i = 0; i < 2; i++) chk("error_one_cycle", 32'(error_v[i]), 0);
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
            for (int i = 0; i < 2; i++) chk("fbc_vsync_hold", 32'(fbc_vsync_v[i]), 32'(written));
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
            for (int i = 0; i < 2; i++) chk("fbc_vsync_end", 32'(fbc_vsync_v[i]), 0);
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
        for (int l = 0; l < nlines; l++) begin
            len = (l == bad_line) ? bad_len : H;
            for (int x = 0; x < len; x++) begin
                d = 24'($urandom);
                cycle(1'b0, 1'b0, 1'b1, d, written && !rst_hit && l < V && x < H);
                if (l == rst_line && x == 2 && !rst_hit) begin
                    reset_midline();
                    rst_hit = 1;
                end
            end
            if (!(coinc && l == nlines - 1)) begin
                cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
                repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
            end
        end
        good = (nlines == V) && (bad_line < 0 || bad_line >= nlines || bad_len == H);
        prev_valid   = has_vs && !rst_hit;
        prev_good    = good;
        prev_written = written && !rst_hit;
    endtask

    initial begin
        int kind, nl, bl, blen;
        bit co;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_we", 32'(fbc_we_v[i]), 0);
            chk("reset_vsync", 32'(fbc_vsync_v[i]), 0);
            chk("reset_locked", 32'(locked_v[i]), 0);
            chk("reset_error", 32'(error_v[i]), 0);
        end
        chk("reset_data_pos", 32'(data_v0), 0);
        chk("reset_data_neg", 32'(data_v1), 0);
        reset_n = 1'b1;

        send_frame(0, 2, -1, 0, 0, -1);          // partial frame in progress at reset
        repeat (4) send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V, 2, 7, 0, -1);           // short line while locked
        send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V + 1, -1, 0, 0, -1);      // extra line while locked
        send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V, -1, 0, 1, -1);          // last den_fall coincides with next vsync start
        send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V, 1, 9, 0, -1);           // overlong line while locked
        send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V, -1, 0, 0, 1);           // asynchronous reset mid-line
        send_frame(0, 2, -1, 0, 0, -1);
        send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V, -1, 0, 0, -1);
        send_frame(1, V, -1, 0, 0, -1);

        for (int f = 0; f < 8; f++) begin
            kind = $urandom_range(0, 3);
            nl   = V;
            bl   = -1;
            blen = H;
            co   = 1'($urandom_range(0, 1));
            if (kind == 2) begin
                bl   = $urandom_range(0, V - 1);
                blen = $urandom_range(H - 2, H + 2);
            end else if (kind == 3) begin
                nl = ($urandom_range(0, 1) == 0) ? V - 1 : V + 1;
            end
            send_frame(1, nl, bl, blen, co, -1);
        end
        send_frame(1, 0, -1, 0, 0, -1);

        chk("queue_drained_pos", exp_q0.size(), 0);
        chk("queue_drained_neg", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
